// File: rtl/gun_shot_ctrl.sv
// gun_shot_ctrl: fire-button shot sequencer with magazine, timed reload, bullet flight and bullet pixel layer
module gun_shot_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int MAG_SIZE     = 3,
    parameter int RELOAD_TICKS = 500,
    parameter int SPEED        = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       fire,
    input  logic [9:0] gun_x,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       hit_in,
    output logic [9:0] bullet_x,
    output logic [9:0] bullet_y,
    output logic       bullet_active,
    output logic [2:0] ammo,
    output logic       reloading,
    output logic       shot_fired,
    output logic       hit_out,
    output logic       miss_out,
    output logic       draw,
    output logic [5:0] data
);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int RW = $clog2(RELOAD_TICKS + 1);
    typedef enum logic [1:0] {READY, FLIGHT, RELOAD} state_t;
    state_t state;
    logic sync1, sync2, sync3, fire_edge;
    logic [TW-1:0] tick_cnt;
    logic [RW-1:0] reload_cnt;
    logic tick, in_box, fly_end;
    // fire synchronizer and registered rising-edge detect
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync3     <= 1'b0;
            fire_edge <= 1'b0;
        end else begin
            sync1     <= fire;
            sync2     <= sync1;
            sync3     <= sync2;
            fire_edge <= sync2 & ~sync3;
        end
    end
    // tick strobe, bullet pixel hit test and flight termination condition
    always_comb begin
        tick    = tick_cnt == TW'(TICK_DIV - 1);
        in_box  = bullet_active && hcount >= bullet_x && hcount <= bullet_x + 10'd3 &&
                  vcount >= bullet_y && vcount <= bullet_y + 10'd7;
        fly_end = hit_in || (tick && bullet_y <= 10'(SPEED));
    end
    // free-running motion/reload tick counter
    always_ff @(posedge clk) begin
        tick_cnt <= (reset || tick) ? '0 : tick_cnt + 1'b1;
    end
    // registered bullet pixel layer
    always_ff @(posedge clk) begin
        draw <= !reset && in_box;
        data <= (!reset && in_box) ? 6'b111111 : 6'b000000;
    end
    // shot / flight / reload sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= READY;
            ammo          <= 3'(MAG_SIZE);
            bullet_x      <= '0;
            bullet_y      <= 10'd426;
            bullet_active <= 1'b0;
            reloading     <= 1'b0;
            shot_fired    <= 1'b0;
            hit_out       <= 1'b0;
            miss_out      <= 1'b0;
            reload_cnt    <= '0;
        end else begin
            shot_fired <= 1'b0;
            hit_out    <= 1'b0;
            miss_out   <= 1'b0;
            case (state)
                READY: if (fire_edge && ammo != 3'd0) begin
                    bullet_x      <= gun_x + 10'd29;
                    bullet_y      <= 10'd426;
                    ammo          <= ammo - 3'd1;
                    shot_fired    <= 1'b1;
                    bullet_active <= 1'b1;
                    state         <= FLIGHT;
                end
                FLIGHT: if (fly_end) begin
                    hit_out       <= hit_in;
                    miss_out      <= !hit_in;
                    bullet_active <= 1'b0;
                    reload_cnt    <= '0;
                    reloading     <= ammo == 3'd0;
                    state         <= (ammo == 3'd0) ? RELOAD : READY;
                end else if (tick) begin
                    bullet_y <= bullet_y - 10'(SPEED);
                end
                RELOAD: if (tick) begin
                    if (reload_cnt == RW'(RELOAD_TICKS - 1)) begin
                        ammo      <= 3'(MAG_SIZE);
                        reloading <= 1'b0;
                        state     <= READY;
                    end else begin
                        reload_cnt <= reload_cnt + 1'b1;
                    end
                end
                default: state <= READY;
            endcase
        end
    end
endmodule

// File: tb/tb_gun_shot_ctrl.sv
// tb_gun_shot_ctrl: scenario tasks plus randomized run against an event-level reference model
module tb_gun_shot_ctrl;
    localparam int TD = 4, MAG = 3, RT = 5, SP = 2;
    logic clk = 0, reset = 1, fire = 0, hit_in = 0;
    logic [9:0] gun_x = 0, hcount = 0, vcount = 0;
    logic [9:0] bullet_x, bullet_y;
    logic bullet_active, reloading, shot_fired, hit_out, miss_out, draw;
    logic [2:0] ammo;
    logic [5:0] data;
    int checks = 0, errors = 0;
    int k;
    bit fh[$];
    bit m_flight, m_reload, m_shot, m_hit, m_miss, m_draw;
    int m_ammo, m_x, m_y, m_rt;

    always #5 clk = ~clk;

    gun_shot_ctrl #(.TICK_DIV(TD), .MAG_SIZE(MAG), .RELOAD_TICKS(RT), .SPEED(SP)) dut (
        .clk(clk), .reset(reset), .fire(fire), .gun_x(gun_x), .hcount(hcount), .vcount(vcount),
        .hit_in(hit_in), .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active),
        .ammo(ammo), .reloading(reloading), .shot_fired(shot_fired), .hit_out(hit_out),
        .miss_out(miss_out), .draw(draw), .data(data)
    );

    task automatic model_reset();
        k = 0;
        fh = {1'b0, 1'b0, 1'b0, 1'b0};
        {m_flight, m_reload, m_shot, m_hit, m_miss, m_draw} = '0;
        m_ammo = MAG; m_x = 0; m_y = 426; m_rt = 0;
    endtask

    task automatic end_flight();
        m_flight = 0;
        if (m_ammo == 0) begin m_reload = 1; m_rt = 0; end
    endtask

    // one clock: model applies the rules to the inputs seen at this edge, then DUT is sampled 1 ns later
    task automatic step();
        bit tick, fe;
        tick = (k % TD) == TD - 1;
        fe = fh[2] && !fh[3];
        m_shot = 0; m_hit = 0; m_miss = 0;
        m_draw = m_flight && hcount >= m_x && hcount <= m_x + 3 && vcount >= m_y && vcount <= m_y + 7;
        if (m_flight) begin
            if (hit_in) begin m_hit = 1; end_flight(); end
            else if (tick && m_y <= SP) begin m_miss = 1; end_flight(); end
            else if (tick) m_y -= SP;
        end else if (m_reload) begin
            if (tick) begin
                m_rt++;
                if (m_rt == RT) begin m_reload = 0; m_ammo = MAG; end
            end
        end else if (fe && m_ammo > 0) begin
            m_x = gun_x + 29; m_y = 426; m_ammo--; m_shot = 1; m_flight = 1;
        end
        fh.push_front(fire);
        void'(fh.pop_back());
        k++;
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        model_reset();
    endtask

    task automatic fire_and_wait(input string name);
        int n = 0;
        fire = 1; step(); fire = 0;
        while (!shot_fired && n < 10) begin step(); n++; end
        checks++;
        if (!shot_fired) begin errors++; $display("FAIL %s_shot_timeout got 0 want shot_fired within 10 cycles", name); end
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (ammo !== 3'd3) begin errors++; $display("FAIL reset_ammo got %0d want 3", ammo); end
        checks++; if (bullet_y !== 10'd426 || bullet_x !== 10'd0) begin errors++; $display("FAIL reset_pos got %0d,%0d want 0,426", bullet_x, bullet_y); end
        checks++; if ({bullet_active, reloading, shot_fired, hit_out, miss_out, draw, data} !== 12'd0) begin
            errors++; $display("FAIL reset_flags got %b want 0", {bullet_active, reloading, shot_fired, hit_out, miss_out, draw, data}); end
    endtask

    task automatic test_shot();
        gun_x = 100;
        fire = 1; step(); fire = 0;
        step(); step();
        checks++; if (shot_fired !== 1'b0) begin errors++; $display("FAIL shot_early got %b want 0", shot_fired); end
        step();
        checks++; if (shot_fired !== 1'b1) begin errors++; $display("FAIL shot_latency got %b want 1", shot_fired); end
        checks++; if (bullet_x !== 10'd129 || bullet_y !== 10'd426) begin errors++; $display("FAIL shot_pos got %0d,%0d want 129,426", bullet_x, bullet_y); end
        checks++; if (ammo !== 3'd2 || bullet_active !== 1'b1) begin errors++; $display("FAIL shot_state got ammo %0d active %b want 2,1", ammo, bullet_active); end
        step();
        checks++; if (shot_fired !== 1'b0) begin errors++; $display("FAIL shot_pulse got %b want 0", shot_fired); end
    endtask

    task automatic test_miss();
        int decs = 0, bad = 0, misses = 0, n = 0;
        logic [9:0] prev;
        while (misses == 0 && n < 2000) begin
            prev = bullet_y;
            step(); n++;
            if (miss_out) misses++;
            if (bullet_y != prev) begin decs++; if (prev - bullet_y != SP) bad++; end
        end
        for (int i = 0; i < 4; i++) begin step(); if (miss_out) misses++; end
        checks++; if (misses != 1) begin errors++; $display("FAIL miss_pulses got %0d want 1", misses); end
        checks++; if (decs != 212 || bad != 0) begin errors++; $display("FAIL miss_steps got %0d moves (%0d bad) want 212 (0 bad)", decs, bad); end
        checks++; if (bullet_y !== 10'd2) begin errors++; $display("FAIL miss_final_y got %0d want 2", bullet_y); end
        checks++; if (bullet_active !== 1'b0 || ammo !== 3'd2 || reloading !== 1'b0) begin
            errors++; $display("FAIL miss_state got active %b ammo %0d rel %b want 0,2,0", bullet_active, ammo, reloading); end
    endtask

    task automatic test_hit_vs_tick();
        int n = 0;
        fire_and_wait("hit");
        while (!(bullet_y == 10'd300 && (k % TD) == TD - 1) && n < 1000) begin step(); n++; end
        checks++; if (bullet_y !== 10'd300) begin errors++; $display("FAIL hit_reach300 got %0d want 300", bullet_y); end
        hit_in = 1; step(); hit_in = 0;
        checks++; if (hit_out !== 1'b1 || miss_out !== 1'b0) begin errors++; $display("FAIL hit_pulse got hit %b miss %b want 1,0", hit_out, miss_out); end
        checks++; if (bullet_y !== 10'd300 || bullet_active !== 1'b0 || ammo !== 3'd1) begin
            errors++; $display("FAIL hit_state got y %0d active %b ammo %0d want 300,0,1", bullet_y, bullet_active, ammo); end
        step();
        checks++; if (hit_out !== 1'b0) begin errors++; $display("FAIL hit_single got %b want 0", hit_out); end
    endtask

    task automatic test_reload();
        int ticks = 0, shots = 0, i = 0;
        fire_and_wait("reload");
        hit_in = 1; step(); hit_in = 0;
        checks++; if (reloading !== 1'b1 || ammo !== 3'd0 || bullet_active !== 1'b0) begin
            errors++; $display("FAIL reload_enter got rel %b ammo %0d want 1,0", reloading, ammo); end
        while (reloading && i < 200) begin
            fire = (i < 10) && (i % 2 == 1);
            if ((k % TD) == TD - 1) ticks++;
            step(); i++;
            if (shot_fired) shots++;
        end
        fire = 0;
        checks++; if (ticks != RT || reloading !== 1'b0) begin errors++; $display("FAIL reload_ticks got %0d (rel %b) want %0d", ticks, reloading, RT); end
        checks++; if (ammo !== 3'd3 || shots != 0) begin errors++; $display("FAIL reload_done got ammo %0d shots %0d want 3,0", ammo, shots); end
    endtask

    task automatic test_back_to_back();
        int shots = 0;
        fire = 1;
        for (int i = 0; i < 10; i++) begin step(); if (shot_fired) shots++; end
        hit_in = 1; step(); hit_in = 0;
        for (int i = 0; i < 20; i++) begin step(); if (shot_fired) shots++; end
        checks++; if (shots != 1 || ammo !== 3'd2) begin errors++; $display("FAIL hold_shots got %0d ammo %0d want 1,2", shots, ammo); end
        fire = 0; step(); step();
        fire_and_wait("b2b");
        shots = 0;
        for (int i = 0; i < 16; i++) begin fire = (i % 4) < 2; step(); if (shot_fired) shots++; end
        fire = 0;
        checks++; if (shots != 0 || ammo !== 3'd1 || bullet_active !== 1'b1) begin
            errors++; $display("FAIL flight_ignore got shots %0d ammo %0d active %b want 0,1,1", shots, ammo, bullet_active); end
        for (int i = 0; i < 6; i++) step();
        hit_in = 1; step(); hit_in = 0;
        step();
    endtask

    task automatic test_reset_mid_flight();
        int n = 0;
        fire_and_wait("rst");
        while (bullet_y != 10'd200 && n < 1000) begin step(); n++; end
        hcount = bullet_x; vcount = 10'd200;
        step();
        checks++; if (draw !== 1'b1 || data !== 6'h3f) begin errors++; $display("FAIL rst_draw_before got %b/%h want 1/3f", draw, data); end
        reset = 1;
        @(posedge clk); #1;
        checks++; if (ammo !== 3'd3 || bullet_active !== 1'b0 || reloading !== 1'b0 || bullet_y !== 10'd426) begin
            errors++; $display("FAIL rst_state got ammo %0d active %b rel %b y %0d want 3,0,0,426", ammo, bullet_active, reloading, bullet_y); end
        checks++; if (hit_out !== 1'b0 || miss_out !== 1'b0 || draw !== 1'b0) begin
            errors++; $display("FAIL rst_pulses got hit %b miss %b draw %b want 0,0,0", hit_out, miss_out, draw); end
        reset = 0;
        model_reset();
        step();
        checks++; if (draw !== 1'b0 || data !== 6'd0) begin errors++; $display("FAIL rst_draw_after got %b/%h want 0/0", draw, data); end
    endtask

    task automatic test_random();
        logic [30:0] got, exp;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) fire = ~fire;
            hit_in = $urandom_range(0, 39) == 0;
            gun_x = 10'($urandom_range(0, 578));
            hcount = 10'(m_x + int'($urandom_range(0, 8)) - 2);
            vcount = 10'(m_y + int'($urandom_range(0, 12)) - 2);
            step();
            got = {bullet_active, ammo, reloading, shot_fired, hit_out, miss_out, draw, bullet_x, bullet_y, data == {6{draw}}};
            exp = {m_flight, 3'(m_ammo), m_reload, m_shot, m_hit, m_miss, m_draw, 10'(m_x), 10'(m_y), 1'b1};
            checks++;
            if (got !== exp) begin errors++; $display("FAIL random_cycle_%0d got %h want %h", i, got, exp); end
        end
        fire = 0; hit_in = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_shot();
        test_miss();
        test_hit_vs_tick();
        test_reload();
        test_back_to_back();
        test_reset_mid_flight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
